// File: rtl/evt_counter_bank.sv
// evt_counter_bank
// Bank of NUM_CH modulo-MAX_COUNT up/down event counters with clear, parallel
// load and a registered terminal-count pulse. Selected channels can be chained
// to the rollover of the channel below to build multi-digit counters
// (column -> row -> frame). The rollover ripple is purely combinational, so a
// whole chain rolls over on a single edge.
module evt_counter_bank #(
    parameter int                NUM_CH    = 4,
    parameter int                MAX_COUNT = 255,
    parameter bit                SATURATE  = 1'b0,
    parameter logic [NUM_CH-1:0] CASCADE   = '0,
    parameter int                CW        = $clog2(MAX_COUNT)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_CH-1:0]    evt_in,
    input  logic [NUM_CH-1:0]    dir_in,
    input  logic [NUM_CH-1:0]    clr_in,
    input  logic [NUM_CH-1:0]    load_in,
    input  logic [CW-1:0]        load_val_in,
    output logic [NUM_CH*CW-1:0] count_out,
    output logic [NUM_CH-1:0]    tc_out
);

    // Highest legal count; also the terminal value when counting up.
    localparam logic [CW-1:0] LP_TOP = CW'(MAX_COUNT - 1);

    logic [NUM_CH-1:0][CW-1:0] r_count;
    logic [NUM_CH-1:0]         r_tc;

    logic [NUM_CH-1:0][CW-1:0] w_next;
    logic [NUM_CH-1:0]         w_e;
    logic [NUM_CH-1:0]         w_roll;
    logic [CW-1:0]             w_load_val;

    // A load value beyond the modulus is clamped so the count stays in range.
    assign w_load_val = (load_val_in > LP_TOP) ? LP_TOP : load_val_in;

    // Effective events, rollover ripple and next-count selection, evaluated
    // from channel 0 upward so each channel sees the roll of the one below.
    always_comb begin
        logic v_at_term;
        w_e    = '0;
        w_roll = '0;
        w_next = r_count;
        for (int i = 0; i < NUM_CH; i++) begin
            v_at_term = 1'b0;
            // Cascaded channels ignore their own strobe and follow the roll below.
            if (i == 0 || !CASCADE[i]) begin
                w_e[i] = evt_in[i];
            end else begin
                w_e[i] = w_roll[(i == 0) ? 0 : i - 1];
            end

            // Terminal is the top count going up and zero going down.
            v_at_term = dir_in[i] ? (r_count[i] == '0) : (r_count[i] == LP_TOP);

            // Clear or load wins over the event, so they also suppress the roll.
            w_roll[i] = w_e[i] & v_at_term & ~clr_in[i] & ~load_in[i];

            if (clr_in[i]) begin
                w_next[i] = '0;
            end else if (load_in[i]) begin
                w_next[i] = w_load_val;
            end else if (w_e[i]) begin
                if (v_at_term) begin
                    if (SATURATE) begin
                        w_next[i] = r_count[i];
                    end else begin
                        w_next[i] = dir_in[i] ? LP_TOP : '0;
                    end
                end else begin
                    w_next[i] = dir_in[i] ? (r_count[i] - CW'(1)) : (r_count[i] + CW'(1));
                end
            end
        end
    end

    // Count and terminal-count registers; reset clears any pending tc pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count <= '0;
            r_tc    <= '0;
        end else begin
            r_count <= w_next;
            r_tc    <= w_roll;
        end
    end

    // Pack each channel's count into its slice of the output bus.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
        assign count_out[gi*CW +: CW] = r_count[gi];
    end

    assign tc_out = r_tc;

endmodule

// File: tb/tb_evt_counter_bank.sv
// Scoreboard bench for evt_counter_bank: two instances (wrapping with ch1
// cascaded on ch0, and saturating with independent channels). Stimulus pushes
// hand-computed expectations; a monitor pops and compares after each edge.
module tb_evt_counter_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] w_evt, w_dir, w_clr, w_load;
    logic [3:0] w_lv;
    logic [7:0] w_cnt;
    logic [1:0] w_tc;
    logic [1:0] s_evt, s_dir, s_clr, s_load;
    logic [3:0] s_lv;
    logic [7:0] s_cnt;
    logic [1:0] s_tc;

    evt_counter_bank #(
        .NUM_CH(2), .MAX_COUNT(10), .SATURATE(1'b0), .CASCADE(2'b10)
    ) u_wrap (
        .clk_in(clk), .rst_in(rst), .evt_in(w_evt), .dir_in(w_dir),
        .clr_in(w_clr), .load_in(w_load), .load_val_in(w_lv),
        .count_out(w_cnt), .tc_out(w_tc)
    );

    evt_counter_bank #(
        .NUM_CH(2), .MAX_COUNT(10), .SATURATE(1'b1), .CASCADE(2'b00)
    ) u_sat (
        .clk_in(clk), .rst_in(rst), .evt_in(s_evt), .dir_in(s_dir),
        .clr_in(s_clr), .load_in(s_load), .load_val_in(s_lv),
        .count_out(s_cnt), .tc_out(s_tc)
    );

    typedef struct {
        bit         sat;
        logic [7:0] cnt;
        logic [1:0] tc;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual tc/ch1/ch0=%b/%0d/%0d required=%b/%0d/%0d",
                     nm, act[9:8], act[7:4], act[3:0], req[9:8], req[7:4], req[3:0]);
        end
    endtask

    // Monitor: the outputs are valid every cycle, so compare one pending
    // expectation after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.nm, e.sat ? {s_tc, s_cnt} : {w_tc, w_cnt}, {e.tc, e.cnt});
            end
        end
    end

    task automatic quiet();
        w_evt = '0; w_dir = '0; w_clr = '0; w_load = '0; w_lv = '0;
        s_evt = '0; s_dir = '0; s_clr = '0; s_load = '0; s_lv = '0;
    endtask

    // Drive one cycle of inputs on the selected instance and record what the
    // counters must show after the next rising edge.
    task automatic step(input bit sat, input logic [1:0] evt, input logic [1:0] dir,
                        input logic [1:0] clr, input logic [1:0] load, input logic [3:0] lv,
                        input logic [3:0] e1, input logic [3:0] e0, input logic [1:0] etc,
                        input string nm);
        @(negedge clk);
        quiet();
        if (sat) begin
            s_evt = evt; s_dir = dir; s_clr = clr; s_load = load; s_lv = lv;
        end else begin
            w_evt = evt; w_dir = dir; w_clr = clr; w_load = load; w_lv = lv;
        end
        q.push_back('{sat: sat, cnt: {e1, e0}, tc: etc, nm: nm});
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        repeat (2) @(negedge clk);
        check("rst_wrap", {w_tc, w_cnt}, 10'd0);
        check("rst_sat", {s_tc, s_cnt}, 10'd0);
        rst = 1'b0;

        // Plain up-count on ch0 with cascade into ch1 at the wrap.
        for (int k = 1; k <= 12; k++)
            step(0, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0, (k >= 10) ? 4'd1 : 4'd0,
                 4'(k % 10), (k == 10) ? 2'b01 : 2'b00, $sformatf("t1_evt%0d", k));
        step(0, 2'b10, 2'b00, 2'b00, 2'b00, 4'd0, 4'd1, 4'd2, 2'b00, "t1_casc_evt_ignored");
        step(0, 2'b00, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 4'd0, 2'b00, "t1_clr");

        // Two-digit count: 25 events -> 2,5.
        for (int k = 1; k <= 25; k++)
            step(0, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0, 4'(k / 10), 4'(k % 10),
                 (k % 10 == 0) ? 2'b01 : 2'b00, $sformatf("t2_evt%0d", k));
        step(0, 2'b00, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 4'd0, 2'b00, "t2_clr");

        // Load 7, then count down through the 0 -> 9 wrap.
        step(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd7, 4'd0, 4'd7, 2'b00, "t3_load7");
        for (int k = 1; k <= 8; k++)
            step(0, 2'b01, 2'b01, 2'b00, 2'b00, 4'd0, (k == 8) ? 4'd1 : 4'd0,
                 (k <= 7) ? 4'(7 - k) : 4'd9, (k == 8) ? 2'b01 : 2'b00,
                 $sformatf("t3_down%0d", k));
        step(0, 2'b00, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 4'd0, 2'b00, "t3_clr");

        // Load clamp, then clear beats load beats event (no roll at 9).
        step(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd15, 4'd0, 4'd9, 2'b00, "t4_load_clamp");
        step(0, 2'b01, 2'b00, 2'b01, 2'b01, 4'd15, 4'd0, 4'd0, 2'b00, "t4_clr_prio");

        // Clear of ch0 while at terminal blocks ch1's cascaded step.
        step(0, 2'b00, 2'b00, 2'b00, 2'b11, 4'd15, 4'd9, 4'd9, 2'b00, "t6_load_both");
        step(0, 2'b01, 2'b00, 2'b01, 2'b00, 4'd0, 4'd9, 4'd0, 2'b00, "t6_clr_blocks_casc");
        step(0, 2'b00, 2'b00, 2'b11, 2'b00, 4'd0, 4'd0, 4'd0, 2'b00, "t6_clr");
        step(0, 2'b00, 2'b00, 2'b00, 2'b10, 4'd3, 4'd3, 4'd0, 2'b00, "t6_load_ch1");
        step(0, 2'b00, 2'b00, 2'b00, 2'b01, 4'd9, 4'd3, 4'd9, 2'b00, "t6_load_ch0");
        step(0, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0, 4'd4, 4'd0, 2'b01, "t6_roll_into_ch1");

        // Asynchronous reset between edges while tc is high and ch1 is nonzero.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_rst_wrap", {w_tc, w_cnt}, 10'd0);
        @(negedge clk);
        quiet();
        rst = 1'b0;

        // Saturating instance: hold at 9 with a tc pulse on each overflow attempt.
        for (int k = 1; k <= 12; k++)
            step(1, 2'b01, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, (k < 9) ? 4'(k) : 4'd9,
                 (k >= 10) ? 2'b01 : 2'b00, $sformatf("t5_sat%0d", k));
        step(1, 2'b10, 2'b10, 2'b00, 2'b00, 4'd0, 4'd0, 4'd9, 2'b10, "t5_sat_down_hold");

        @(negedge clk);
        quiet();
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
